// File: rtl/seq_detect_1011.sv
// Moore detector for serial pattern 1,0,1,1 (first bit first, overlap allowed)
// with a saturating detection counter; all outputs are registered.
module seq_detect_1011 #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             d,
  output logic             found,
  output logic [CNT_W-1:0] count,
  output logic [2:0]       state
);

  localparam logic [2:0] S0    = 3'd0;
  localparam logic [2:0] S1    = 3'd1;
  localparam logic [2:0] S10   = 3'd2;
  localparam logic [2:0] S101  = 3'd3;
  localparam logic [2:0] S1011 = 3'd4;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [2:0]       state_q, state_d;
  logic             found_q, found_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             hit;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S0:      if (en) state_d = d ? S1    : S0;
      S1:      if (en) state_d = d ? S1    : S10;
      S10:     if (en) state_d = d ? S101  : S0;
      S101:    if (en) state_d = d ? S1011 : S10;
      S1011:   if (en) state_d = d ? S1    : S10;
      // Illegal codes recover to idle even while en is low.
      default: state_d = S0;
    endcase
  end

  // Only S101 can enter S1011, so this fires once per detection.
  always_comb begin
    hit     = en && d && (state_q == S101);
    count_d = count_q;
    if (hit && (count_q != '1)) begin
      count_d = count_q + CNT_ONE;
    end
  end

  // found is registered alongside state so it is always state == S1011.
  always_comb begin
    found_d = (state_d == S1011);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S0;
      found_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      found_q <= found_d;
      count_q <= count_d;
    end
  end

  assign state = state_q;
  assign found = found_q;
  assign count = count_q;

endmodule

// File: tb/tb_seq_detect_1011.sv
// Bench for seq_detect_1011: directed cases with literal expectations plus
// randomized traffic compared every cycle against a bit-history model.
module tb_seq_detect_1011;

  localparam int unsigned CNT_W = 8;
  localparam int MAXC = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             en = 1'b1;
  logic             d = 1'b1;
  logic             found;
  logic [CNT_W-1:0] count;
  logic [2:0]       state;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  seq_detect_1011 #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .d     (d),
    .found (found),
    .count (count),
    .state (state)
  );

  always #5 clk = ~clk;

  // Model: last four accepted bits (bit 0 newest), how many were accepted
  // since reset (capped at 4), and total detections since reset.
  logic [3:0] m_hist = '0;
  int         m_n    = 0;
  int         m_det  = 0;

  // Expected state = length of the longest suffix of the accepted history
  // that is a prefix of 1,0,1,1 (4 means the full pattern just completed).
  function automatic int exp_state(input logic [3:0] h, input int n);
    logic [3:0] pat;
    bit ok;
    pat = 4'b1011;
    for (int len = 4; len >= 1; len--) begin
      if (len <= n) begin
        ok = 1'b1;
        for (int k = 0; k < len; k++) begin
          if (h[len-1-k] != pat[3-k]) ok = 1'b0;
        end
        if (ok) return len;
      end
    end
    return 0;
  endfunction

  always @(posedge clk) begin
    logic [3:0] nh;
    int nn;
    if (reset) begin
      m_hist <= '0;
      m_n    <= 0;
      m_det  <= 0;
    end else if (en) begin
      nh = {m_hist[2:0], d};
      nn = (m_n < 4) ? m_n + 1 : 4;
      m_hist <= nh;
      m_n    <= nn;
      if (exp_state(nh, nn) == 4) m_det <= m_det + 1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int es;
    if (chk_en) begin
      es = exp_state(m_hist, m_n);
      check("model_state", int'(state), es);
      check("model_found", int'(found), (es == 4) ? 1 : 0);
      check("model_count", int'(count), (m_det > MAXC) ? MAXC : m_det);
    end
  end

  task automatic step(input logic r, input logic e, input logic b);
    @(negedge clk);
    reset = r;
    en    = e;
    d     = b;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input int st, input int fd, input int ct);
    check({name, "_state"}, int'(state), st);
    check({name, "_found"}, int'(found), fd);
    check({name, "_count"}, int'(count), ct);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq[7];
    int fexp[7];
    int c0;

    // Reset held for two edges with en=1, d=1.
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    lit("rst1", 0, 0, 0);
    step(1, 1, 1);
    lit("rst2", 0, 0, 0);

    // Basic detect.
    step(0, 1, 1); lit("basic1", 1, 0, 0);
    step(0, 1, 0); lit("basic2", 2, 0, 0);
    step(0, 1, 1); lit("basic3", 3, 0, 0);
    step(0, 1, 1); lit("basic4", 4, 1, 1);

    // found held while en=0 keeps the FSM in S1011.
    step(0, 0, 0); lit("hold1", 4, 1, 1);
    step(0, 0, 1); lit("hold2", 4, 1, 1);

    // Overlap.
    step(1, 1, 1); lit("ovl_rst", 0, 0, 0);
    seq  = '{1, 0, 1, 1, 0, 1, 1};
    fexp = '{0, 0, 0, 1, 0, 0, 1};
    for (int i = 0; i < 7; i++) begin
      step(0, 1, seq[i][0]);
      check($sformatf("ovl_found%0d", i + 1), int'(found), fexp[i]);
    end
    check("ovl_count", int'(count), 2);

    // Enable gap: gap bits ignored.
    step(1, 1, 1);
    step(0, 1, 1);
    step(0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1);
      check($sformatf("gap_state%0d", i), int'(state), 2);
    end
    step(0, 1, 1); lit("gap_a", 3, 0, 0);
    step(0, 1, 1); lit("gap_b", 4, 1, 1);

    // Mid-pattern reset discards history; reset beats en/d.
    step(1, 1, 1);
    step(0, 1, 1);
    step(0, 1, 0);
    step(0, 1, 1);
    step(1, 1, 1); lit("mid_rst", 0, 0, 0);
    step(0, 1, 1); lit("mid_after", 1, 0, 0);

    // Saturation: 1 then 256 x (0,1,1).
    step(1, 1, 1);
    step(0, 1, 1);
    for (int i = 1; i <= 256; i++) begin
      step(0, 1, 0);
      step(0, 1, 1);
      step(0, 1, 1);
      check($sformatf("sat_found%0d", i), int'(found), 1);
      if (i == 254) check("sat_count254", int'(count), 254);
      if (i == 255) check("sat_count255", int'(count), 255);
    end
    check("sat_count_final", int'(count), 255);
    step(0, 1, 0);
    step(0, 1, 1);
    step(0, 1, 1);
    lit("sat_more", 4, 1, 255);

    // Randomized traffic, model-checked every cycle.
    step(1, 1, 0);
    c0 = 0;
    for (int i = 0; i < 3000; i++) begin
      logic r, e, b;
      r = ($urandom_range(0, 199) == 0);
      e = ($urandom_range(0, 9) < 7);
      b = ($urandom_range(0, 9) < 6);
      step(r, e, b);
      if (found) c0++;
    end
    check("rand_saw_detect", (c0 > 0) ? 1 : 0, 1);

    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
